alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have ports: i_Clk in 1 system clock; i_Reset_n in 1 reset, asynchronous and active-low.
REQ-002 SHALL have i_Enable in 1: clock enable; all state advances only when high.
REQ-003 SHALL have i_Valid in 1, o_Ready out 1: instruction-byte handshake; transfer occurs when both are high on a rising edge with i_Enable.
REQ-004 SHALL have i_Opcode in 8 (instruction byte) and i_Operand in 8 (register or immediate value for the op).
REQ-005 SHALL drive the ALU through: o_ALU_Opcode out 8, o_ALU_Parameter out 8, o_ALU_Function_Control out 6, o_ALU_Save_Flags out 1, o_ALU_Write out 2, o_ALU_Data out 8.
REQ-006 SHALL have i_ALU_Result in 8: ALU function output.
REQ-007 SHALL have o_Result out 8, o_Result_Valid out 1, o_Dest out 3 (register index r for non-A results), o_Done out 1, o_Illegal out 1.

Function
REQ-008 States SHALL be IDLE, EXEC, WB; o_Ready = 1 only in IDLE.
REQ-009 Acceptance in IDLE SHALL register opcode, operand and decoded class, then enter EXEC.
REQ-010 Classes: MAIN 10xxxxxx and 11xxx110 -> FC=000001; INC 00rrr100 -> FC=000010; DEC 00rrr101 -> FC=000110; ROTA 0x07/0x0F/0x17/0x1F -> FC=011000; MISC 0x27/0x2F/0x37/0x3F -> FC=100000; CB-prefixed byte -> FC=001000; anything else ILLEGAL.
REQ-011 In EXEC: o_ALU_Opcode = registered opcode, o_ALU_Parameter = registered operand, FC per class, o_ALU_Save_Flags=1 except CB 1xxxxxxx (RES/SET) which is 0; i_ALU_Result captured into o_Result at end of EXEC.
REQ-012 Destination A (MAIN except CP 10111xxx/11111110; INC/DEC with r=7; ROTA; CPL; CB with r=7 excluding 01xxxxxx): EXEC -> WB; WB drives o_ALU_Write=01, o_ALU_Data=o_Result, o_Done=1; WB -> IDLE.
REQ-013 Non-A register destination (INC/DEC r!=7, CB r!=7 excluding 01xxxxxx): o_Result_Valid=1 and o_Dest=r for one cycle in WB, o_ALU_Write=00, o_Done=1.
REQ-014 Flags-only ops (CP, SCF, CCF, DAA result still to A, CB BIT 01xxxxxx): CP/SCF/CCF/BIT assert o_Done in EXEC and return to IDLE; DAA follows REQ-012.
REQ-015 0xCB accepted in IDLE SHALL set cb_pending, stay IDLE, no o_Done; next accepted byte decodes as CB class and clears cb_pending.
REQ-016 ILLEGAL SHALL assert o_Illegal and o_Done for one cycle in EXEC, FC=000000, Save_Flags=0, no write.
REQ-017 All ALU drive outputs SHALL be 0 outside EXEC/WB except as stated; o_Done, o_Illegal, o_Result_Valid are single-cycle pulses.
REQ-018 i_Enable low SHALL freeze state, registers and outputs; pulses held, not repeated, until next enabled edge.
REQ-019 Latency: A-destination op done 2 enabled cycles after acceptance; flags-only/illegal 1 cycle.

Reset
REQ-020 Reset SHALL force IDLE, cb_pending=0, o_Result=0x00, all outputs 0 except o_Ready=1, at any time including mid-EXEC/WB (aborted op performs no write).

Configuration
REQ-021 Macro ALU_SEQ_CB_PREFIX_EN defined: REQ-015 active. Undefined: 0xCB is ILLEGAL, no cb_pending storage, CB class absent.

Structure
REQ-022 Package alu_seq_pkg SHALL hold state enum, class enum, FC bit-position constants, opcode pattern constants.
REQ-023 Combinational decoder SHALL be sub-module alu_seq_decode (opcode, cb flag -> class, FC, save_flags, dest, writes_a); state machine in alu_sequencer.

Verification
REQ-024 Reset asserted mid-WB -> next cycle IDLE, o_Ready=1, o_ALU_Write=00, all other outputs 0.
REQ-025 ADD A,B 0x80, operand 0x3A, i_ALU_Result=0x7F -> EXEC FC=000001, Save_Flags=1, Parameter=0x3A; WB o_ALU_Write=01, o_ALU_Data=0x7F, o_Done=1.
REQ-026 CP 0xFE, operand 0x10 -> EXEC FC=000001, o_Done=1, never o_ALU_Write!=00, back in IDLE next cycle.
REQ-027 INC C 0x0C, operand 0xFF, result 0x00 -> EXEC FC=000010; WB o_Result_Valid=1, o_Dest=1, o_Result=0x00, o_Done=1.
REQ-028 0xCB then 0x11 (RL C) with macro -> no o_Done after first byte, second EXEC FC=001000, WB o_Dest=1; without macro 0xCB -> o_Illegal=1.
REQ-029 i_Enable low 3 cycles during EXEC of 0x80 -> state, FC and Parameter held; WB occurs on first enabled edge after.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer:
// FSM states, decode classes, ALU function-control bits and opcode patterns.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned FC_W   = 6;
  localparam int unsigned REG_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_MAIN    = 3'd1,
    CLS_INC     = 3'd2,
    CLS_DEC     = 3'd3,
    CLS_ROTA    = 3'd4,
    CLS_MISC    = 3'd5,
    CLS_CB      = 3'd6
  } class_e;

  // Bit positions inside the ALU function-control word
  localparam int unsigned FC_B_ARITH  = 0;
  localparam int unsigned FC_B_INCDEC = 1;
  localparam int unsigned FC_B_DEC    = 2;
  localparam int unsigned FC_B_SHIFT  = 3;
  localparam int unsigned FC_B_ACC    = 4;
  localparam int unsigned FC_B_MISC   = 5;

  function automatic logic [FC_W-1:0] fc_bit(input int unsigned pos);
    return FC_W'(1) << pos;
  endfunction

  localparam logic [FC_W-1:0] FC_NONE = '0;
  localparam logic [FC_W-1:0] FC_MAIN = fc_bit(FC_B_ARITH);
  localparam logic [FC_W-1:0] FC_INC  = fc_bit(FC_B_INCDEC);
  localparam logic [FC_W-1:0] FC_DEC  = fc_bit(FC_B_INCDEC) | fc_bit(FC_B_DEC);
  localparam logic [FC_W-1:0] FC_ROTA = fc_bit(FC_B_SHIFT) | fc_bit(FC_B_ACC);
  localparam logic [FC_W-1:0] FC_MISC = fc_bit(FC_B_MISC);
  localparam logic [FC_W-1:0] FC_CB   = fc_bit(FC_B_SHIFT);

  localparam logic [DATA_W-1:0] OPC_CB_PREFIX = 8'hCB;
  localparam logic [DATA_W-1:0] OPC_CP_IMM    = 8'hFE;
  localparam logic [DATA_W-1:0] OPC_DAA       = 8'h27;
  localparam logic [DATA_W-1:0] OPC_CPL       = 8'h2F;
  localparam logic [4:0]        OPC_CP_REG_HI = 5'b10111;
  localparam logic [2:0]        OPC_ACC_LO    = 3'b111;
  localparam logic [2:0]        OPC_INC_LO    = 3'b100;
  localparam logic [2:0]        OPC_DEC_LO    = 3'b101;
  localparam logic [2:0]        OPC_IMM_LO    = 3'b110;
  localparam logic [2:0]        OPC_ROTA_HI   = 3'b000;
  localparam logic [2:0]        OPC_MISC_HI   = 3'b001;
  localparam logic [1:0]        OPC_CB_BIT_HI = 2'b01;
  localparam logic [REG_W-1:0]  REG_A         = 3'd7;

  typedef struct packed {
    class_e            cls;
    logic [FC_W-1:0]   fc;
    logic              save_flags;
    logic [REG_W-1:0]  dest;
    logic              writes_a;
    logic              writes_reg;
  } decode_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction-byte decoder: opcode plus CB-prefix flag to
// class, function control, flag-save enable and destination.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [DATA_W-1:0] opcode_i,
  input  logic              cb_flag_i,
  output decode_t           dec_o
);

  logic [REG_W-1:0] r_mid;
  logic [REG_W-1:0] r_low;

  assign r_mid = opcode_i[5:3];
  assign r_low = opcode_i[2:0];

  always_comb begin
    dec_o     = '0;
    dec_o.cls = CLS_ILLEGAL;
    if (cb_flag_i) begin
      // BIT tests only flags; RES/SET leave flags untouched
      dec_o.cls        = CLS_CB;
      dec_o.fc         = FC_CB;
      dec_o.save_flags = ~opcode_i[7];
      dec_o.dest       = r_low;
      if (opcode_i[7:6] != OPC_CB_BIT_HI) begin
        dec_o.writes_a   = (r_low == REG_A);
        dec_o.writes_reg = (r_low != REG_A);
      end
    end else if ((opcode_i[7:6] == 2'b10) ||
                 ((opcode_i[7:6] == 2'b11) && (r_low == OPC_IMM_LO))) begin
      dec_o.cls        = CLS_MAIN;
      dec_o.fc         = FC_MAIN;
      dec_o.save_flags = 1'b1;
      dec_o.dest       = REG_A;
      dec_o.writes_a   = !((opcode_i[7:3] == OPC_CP_REG_HI) || (opcode_i == OPC_CP_IMM));
    end else if ((opcode_i[7:6] == 2'b00) && (r_low == OPC_INC_LO)) begin
      dec_o.cls        = CLS_INC;
      dec_o.fc         = FC_INC;
      dec_o.save_flags = 1'b1;
      dec_o.dest       = r_mid;
      dec_o.writes_a   = (r_mid == REG_A);
      dec_o.writes_reg = (r_mid != REG_A);
    end else if ((opcode_i[7:6] == 2'b00) && (r_low == OPC_DEC_LO)) begin
      dec_o.cls        = CLS_DEC;
      dec_o.fc         = FC_DEC;
      dec_o.save_flags = 1'b1;
      dec_o.dest       = r_mid;
      dec_o.writes_a   = (r_mid == REG_A);
      dec_o.writes_reg = (r_mid != REG_A);
    end else if ((opcode_i[7:5] == OPC_ROTA_HI) && (r_low == OPC_ACC_LO)) begin
      dec_o.cls        = CLS_ROTA;
      dec_o.fc         = FC_ROTA;
      dec_o.save_flags = 1'b1;
      dec_o.dest       = REG_A;
      dec_o.writes_a   = 1'b1;
    end else if ((opcode_i[7:5] == OPC_MISC_HI) && (r_low == OPC_ACC_LO)) begin
      // DAA and CPL update A; SCF and CCF touch only flags
      dec_o.cls        = CLS_MISC;
      dec_o.fc         = FC_MISC;
      dec_o.save_flags = 1'b1;
      dec_o.dest       = REG_A;
      dec_o.writes_a   = (opcode_i == OPC_DAA) || (opcode_i == OPC_CPL);
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// ALU instruction sequencer: accepts instruction bytes, drives the ALU for one
// EXEC cycle and writes back the result. Build macro: ALU_SEQ_CB_PREFIX_EN.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic              i_Clk,
  input  logic              i_Reset_n,
  input  logic              i_Enable,
  input  logic              i_Valid,
  output logic              o_Ready,
  input  logic [DATA_W-1:0] i_Opcode,
  input  logic [DATA_W-1:0] i_Operand,
  output logic [DATA_W-1:0] o_ALU_Opcode,
  output logic [DATA_W-1:0] o_ALU_Parameter,
  output logic [FC_W-1:0]   o_ALU_Function_Control,
  output logic              o_ALU_Save_Flags,
  output logic [1:0]        o_ALU_Write,
  output logic [DATA_W-1:0] o_ALU_Data,
  input  logic [DATA_W-1:0] i_ALU_Result,
  output logic [DATA_W-1:0] o_Result,
  output logic              o_Result_Valid,
  output logic [REG_W-1:0]  o_Dest,
  output logic              o_Done,
  output logic              o_Illegal
);

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_A    = 2'b01;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  decode_t           dec_q, dec_d;
  decode_t           dec_w;
  logic              cb_flag;
  logic              prefix_hit;
  logic              accept;

  logic              ready_q, ready_d;
  logic [DATA_W-1:0] alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0] alu_param_q, alu_param_d;
  logic [FC_W-1:0]   alu_fc_q, alu_fc_d;
  logic              alu_save_q, alu_save_d;
  logic [1:0]        alu_write_q, alu_write_d;
  logic [DATA_W-1:0] alu_data_q, alu_data_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;

`ifdef ALU_SEQ_CB_PREFIX_EN
  logic cb_pending_q, cb_pending_d;

  assign cb_flag    = cb_pending_q;
  assign prefix_hit = !cb_pending_q && (i_Opcode == OPC_CB_PREFIX);

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cb_pending_q <= 1'b0;
    end else if (i_Enable) begin
      cb_pending_q <= cb_pending_d;
    end
  end

  // Prefix arms on its own byte and is consumed by the next accepted byte
  always_comb begin
    cb_pending_d = cb_pending_q;
    if (accept) begin
      cb_pending_d = prefix_hit;
    end
  end
`else
  assign cb_flag    = 1'b0;
  assign prefix_hit = 1'b0;
`endif

  alu_seq_decode u_decode (
    .opcode_i  (i_Opcode),
    .cb_flag_i (cb_flag),
    .dec_o     (dec_w)
  );

  assign accept = (state_q == ST_IDLE) && ready_q && i_Valid;

  // Next state and operation registers
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    dec_d     = dec_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !prefix_hit) begin
          state_d   = ST_EXEC;
          opcode_d  = i_Opcode;
          operand_d = i_Operand;
          dec_d     = dec_w;
        end
      end
      ST_EXEC: begin
        if (dec_q.cls != CLS_ILLEGAL) begin
          result_d = i_ALU_Result;
        end
        state_d = (dec_q.writes_a || dec_q.writes_reg) ? ST_WB : ST_IDLE;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are computed from the state being entered
  always_comb begin
    ready_d        = (state_d == ST_IDLE);
    alu_opcode_d   = '0;
    alu_param_d    = '0;
    alu_fc_d       = FC_NONE;
    alu_save_d     = 1'b0;
    alu_write_d    = WR_NONE;
    alu_data_d     = '0;
    result_valid_d = 1'b0;
    dest_d         = '0;
    done_d         = 1'b0;
    illegal_d      = 1'b0;
    case (state_d)
      ST_EXEC: begin
        alu_opcode_d = opcode_d;
        alu_param_d  = operand_d;
        alu_fc_d     = dec_d.fc;
        alu_save_d   = dec_d.save_flags;
        done_d       = !(dec_d.writes_a || dec_d.writes_reg);
        illegal_d    = (dec_d.cls == CLS_ILLEGAL);
      end
      ST_WB: begin
        done_d = 1'b1;
        if (dec_d.writes_a) begin
          alu_write_d = WR_A;
          alu_data_d  = result_d;
        end
        if (dec_d.writes_reg) begin
          result_valid_d = 1'b1;
          dest_d         = dec_d.dest;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q        <= ST_IDLE;
      opcode_q       <= '0;
      operand_q      <= '0;
      dec_q          <= '0;
      ready_q        <= 1'b1;
      alu_opcode_q   <= '0;
      alu_param_q    <= '0;
      alu_fc_q       <= FC_NONE;
      alu_save_q     <= 1'b0;
      alu_write_q    <= WR_NONE;
      alu_data_q     <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      dest_q         <= '0;
      done_q         <= 1'b0;
      illegal_q      <= 1'b0;
    end else if (i_Enable) begin
      state_q        <= state_d;
      opcode_q       <= opcode_d;
      operand_q      <= operand_d;
      dec_q          <= dec_d;
      ready_q        <= ready_d;
      alu_opcode_q   <= alu_opcode_d;
      alu_param_q    <= alu_param_d;
      alu_fc_q       <= alu_fc_d;
      alu_save_q     <= alu_save_d;
      alu_write_q    <= alu_write_d;
      alu_data_q     <= alu_data_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      dest_q         <= dest_d;
      done_q         <= done_d;
      illegal_q      <= illegal_d;
    end
  end

  assign o_Ready                = ready_q;
  assign o_ALU_Opcode           = alu_opcode_q;
  assign o_ALU_Parameter        = alu_param_q;
  assign o_ALU_Function_Control = alu_fc_q;
  assign o_ALU_Save_Flags       = alu_save_q;
  assign o_ALU_Write            = alu_write_q;
  assign o_ALU_Data             = alu_data_q;
  assign o_Result               = result_q;
  assign o_Result_Valid         = result_valid_q;
  assign o_Dest                 = dest_q;
  assign o_Done                 = done_q;
  assign o_Illegal              = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; follows ALU_SEQ_CB_PREFIX_EN
// to choose the expected behaviour of the 0xCB prefix byte.
module tb_alu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       valid;
  logic       ready;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic [7:0] alu_opcode;
  logic [7:0] alu_param;
  logic [5:0] alu_fc;
  logic       alu_save;
  logic [1:0] alu_write;
  logic [7:0] alu_data;
  logic [7:0] alu_result;
  logic [7:0] result;
  logic       result_valid;
  logic [2:0] dest;
  logic       done;
  logic       illegal;

  int n_checks;
  int n_fail;

  alu_sequencer dut (
    .i_Clk                  (clk),
    .i_Reset_n              (rst_n),
    .i_Enable               (enable),
    .i_Valid                (valid),
    .o_Ready                (ready),
    .i_Opcode               (opcode),
    .i_Operand              (operand),
    .o_ALU_Opcode           (alu_opcode),
    .o_ALU_Parameter        (alu_param),
    .o_ALU_Function_Control (alu_fc),
    .o_ALU_Save_Flags       (alu_save),
    .o_ALU_Write            (alu_write),
    .o_ALU_Data             (alu_data),
    .i_ALU_Result           (alu_result),
    .o_Result               (result),
    .o_Result_Valid         (result_valid),
    .o_Dest                 (dest),
    .o_Done                 (done),
    .o_Illegal              (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] op, input logic [7:0] opd);
    valid   = 1'b1;
    opcode  = op;
    operand = opd;
    tick();
    valid   = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'h1);
    check({tag, "_write"}, 32'(alu_write), 32'h0);
    check({tag, "_done"},  32'(done), 32'h0);
    check({tag, "_fc"},    32'(alu_fc), 32'h0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    enable     = 1'b1;
    valid      = 1'b0;
    opcode     = 8'h00;
    operand    = 8'h00;
    alu_result = 8'h00;
    tick();
    tick();
    check_idle("rst");
    check("rst_result", 32'(result), 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    rst_n = 1'b1;
    tick();

    // ADD A,B
    alu_result = 8'h7F;
    send(8'h80, 8'h3A);
    check("add_fc",     32'(alu_fc), 32'h01);
    check("add_save",   32'(alu_save), 32'h1);
    check("add_param",  32'(alu_param), 32'h3A);
    check("add_opcode", 32'(alu_opcode), 32'h80);
    check("add_ready",  32'(ready), 32'h0);
    check("add_edone",  32'(done), 32'h0);
    tick();
    check("add_write",  32'(alu_write), 32'h1);
    check("add_data",   32'(alu_data), 32'h7F);
    check("add_done",   32'(done), 32'h1);
    check("add_result", 32'(result), 32'h7F);
    check("add_rv",     32'(result_valid), 32'h0);
    tick();
    check_idle("add_end");

    // CP n: flags only, done in EXEC
    alu_result = 8'h55;
    send(8'hFE, 8'h10);
    check("cp_fc",    32'(alu_fc), 32'h01);
    check("cp_done",  32'(done), 32'h1);
    check("cp_write", 32'(alu_write), 32'h0);
    check("cp_save",  32'(alu_save), 32'h1);
    tick();
    check_idle("cp_end");

    // INC C: non-A destination
    alu_result = 8'h00;
    send(8'h0C, 8'hFF);
    check("inc_fc",    32'(alu_fc), 32'h02);
    check("inc_edone", 32'(done), 32'h0);
    tick();
    check("inc_rv",     32'(result_valid), 32'h1);
    check("inc_dest",   32'(dest), 32'h1);
    check("inc_result", 32'(result), 32'h00);
    check("inc_done",   32'(done), 32'h1);
    check("inc_write",  32'(alu_write), 32'h0);
    tick();
    check("inc_rv_end", 32'(result_valid), 32'h0);
    check_idle("inc_end");

    // DEC A
    alu_result = 8'h41;
    send(8'h3D, 8'h42);
    check("dec_fc", 32'(alu_fc), 32'h06);
    tick();
    check("dec_write", 32'(alu_write), 32'h1);
    check("dec_data",  32'(alu_data), 32'h41);
    tick();

    // RLCA
    alu_result = 8'h03;
    send(8'h07, 8'h81);
    check("rota_fc", 32'(alu_fc), 32'h18);
    tick();
    check("rota_data", 32'(alu_data), 32'h03);
    tick();

    // SCF: flags only
    send(8'h37, 8'h00);
    check("scf_fc",    32'(alu_fc), 32'h20);
    check("scf_done",  32'(done), 32'h1);
    check("scf_write", 32'(alu_write), 32'h0);
    tick();
    check("scf_ready", 32'(ready), 32'h1);

    // Illegal byte
    send(8'h00, 8'h00);
    check("ill_flag",  32'(illegal), 32'h1);
    check("ill_done",  32'(done), 32'h1);
    check("ill_fc",    32'(alu_fc), 32'h0);
    check("ill_save",  32'(alu_save), 32'h0);
    tick();
    check("ill_clear", 32'(illegal), 32'h0);
    check_idle("ill_end");

`ifdef ALU_SEQ_CB_PREFIX_EN
    send(8'hCB, 8'h00);
    check("cb1_ready", 32'(ready), 32'h1);
    check("cb1_done",  32'(done), 32'h0);
    alu_result = 8'h22;
    send(8'h11, 8'h00);
    check("cb2_fc",   32'(alu_fc), 32'h08);
    check("cb2_save", 32'(alu_save), 32'h1);
    tick();
    check("cb2_dest",  32'(dest), 32'h1);
    check("cb2_rv",    32'(result_valid), 32'h1);
    check("cb2_write", 32'(alu_write), 32'h0);
    check("cb2_done",  32'(done), 32'h1);
    tick();
`else
    send(8'hCB, 8'h00);
    check("cb_illegal", 32'(illegal), 32'h1);
    check("cb_done",    32'(done), 32'h1);
    tick();
`endif

    // Clock enable low holds EXEC
    alu_result = 8'h99;
    send(8'h80, 8'h44);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_fc",    32'(alu_fc), 32'h01);
      check("hold_param", 32'(alu_param), 32'h44);
      check("hold_write", 32'(alu_write), 32'h0);
    end
    enable = 1'b1;
    tick();
    check("hold_wb_write", 32'(alu_write), 32'h1);
    check("hold_wb_data",  32'(alu_data), 32'h99);
    check("hold_wb_done",  32'(done), 32'h1);
    tick();

    // Reset during WB aborts the write
    alu_result = 8'h33;
    send(8'h80, 8'h12);
    tick();
    check("pre_rst_write", 32'(alu_write), 32'h1);
    rst_n = 1'b0;
    tick();
    check_idle("wbrst");
    check("wbrst_data",   32'(alu_data), 32'h0);
    check("wbrst_result", 32'(result), 32'h0);
    check("wbrst_rv",     32'(result_valid), 32'h0);
    check("wbrst_param",  32'(alu_param), 32'h0);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
